// File: rtl/dma_pkg.sv
// Shared types for the DMA priority arbiter: channel index, FSM states and
// the priority search used for winner selection.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } dma_state_e;

  // Returns the first pending channel found when scanning upward from start (mod 4).
  function automatic ch_idx_t pick_winner(input logic [NUM_CH-1:0] pend, input ch_idx_t start);
    ch_idx_t idx;
    pick_winner = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + ch_idx_t'(i);
      if (pend[idx]) pick_winner = idx;
    end
  endfunction

endpackage

// File: rtl/dma_dreq_sync.sv
// Multi-stage synchronizer for the asynchronous DREQ lines; flops reset to
// the inactive (zero) level, so inputs must already be normalised active-high.
module dma_dreq_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] dreq_raw,
  output logic [WIDTH-1:0] dreq_sync
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= dreq_raw;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dreq_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: HRQ/HLDA handshake with the CPU, fixed or
// rotating channel priority, and polarity-configurable DREQ/DACK.
module dma_priority_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              rot_pri,
  input  logic              dreq_sense,
  input  logic              dack_sense,
  input  logic              ctrl_disable,
  output logic              grant_valid,
  output logic [1:0]        grant_ch,
  input  logic              svc_done
);

  import dma_pkg::*;

  dma_state_e        state_q, state_d;
  ch_idx_t           grant_ch_q, grant_ch_d;
  ch_idx_t           rot_q, rot_d;
  ch_idx_t           winner;
  logic [NUM_CH-1:0] dreq_norm, dreq_sync, pending, dack_act;

  // Normalise before syncing so the flops' reset value is always "inactive".
  assign dreq_norm = DREQ ^ {NUM_CH{dreq_sense}};

  dma_dreq_sync #(
    .WIDTH      (NUM_CH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dreq_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .dreq_raw (dreq_norm),
    .dreq_sync(dreq_sync)
  );

  assign pending = (dreq_sync | sw_req) & ~mask;
  assign winner  = pick_winner(pending, rot_pri ? rot_q : ch_idx_t'(0));

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    rot_d      = rot_q;
    unique case (state_q)
      IDLE: begin
        if (|pending && !ctrl_disable) state_d = REQ;
      end
      REQ: begin
        if (ctrl_disable) begin
          state_d = RELEASE;
        end else if (HLDA) begin
          if (|pending) begin
            state_d    = GRANT;
            grant_ch_d = winner;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      GRANT: begin
        // Losing HLDA aborts without touching the rotation pointer.
        if (!HLDA) begin
          state_d = IDLE;
        end else if (svc_done) begin
          state_d = RELEASE;
          rot_d   = grant_ch_q + ch_idx_t'(1);
        end
      end
      RELEASE: begin
        if (!HLDA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      grant_ch_q <= '0;
      rot_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      rot_q      <= rot_d;
    end
  end

  assign HRQ         = (state_q == REQ) || (state_q == GRANT);
  assign grant_valid = (state_q == GRANT);
  assign grant_ch    = grant_ch_q;
  assign dack_act    = grant_valid ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch_q) : '0;
  assign DACK        = dack_sense ? dack_act : ~dack_act;

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter: NUM_CH, 4, number of DMA channels; only 4 is supported.
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop depth of the DREQ synchronizer.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 DREQ  in  4  asynchronous peripheral request lines; polarity set by dreq_sense.
REQ-006 HLDA  in  1  hold acknowledge from CPU.
REQ-007 HRQ  out  1  hold request to CPU.
REQ-008 DACK  out  4  channel acknowledge; polarity set by dack_sense.
REQ-009 mask  in  4  per-channel mask bits; 1 = request ignored.
REQ-010 sw_req  in  4  software request bits; already synchronous, bypass the synchronizer.
REQ-011 rot_pri  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
REQ-012 dreq_sense  in  1  0 = DREQ active-high, 1 = DREQ active-low.
REQ-013 dack_sense  in  1  0 = DACK active-low, 1 = DACK active-high.
REQ-014 ctrl_disable  in  1  controller disable; blocks new HRQ.
REQ-015 grant_valid  out  1  high while a channel is in service; drives the timing-control FSM.
REQ-016 grant_ch  out  2  index of the channel in service; valid only while grant_valid = 1.
REQ-017 svc_done  in  1  single-cycle pulse from timing control marking end of service (TC, EOP or single-transfer end).

Function
REQ-018 Pending vector = (synced DREQ normalised by dreq_sense | sw_req) & ~mask.
REQ-019 FSM states:
  - IDLE -> REQ when the pending vector is non-zero and ctrl_disable = 0.
  - REQ -> GRANT on the cycle HLDA is sampled high and pending is non-zero.
  - REQ -> RELEASE when HLDA is sampled high and pending = 0 (request withdrawn).
  - GRANT -> RELEASE on svc_done.
  - RELEASE -> IDLE when HLDA is sampled low.
REQ-020 HRQ = 1 in REQ and GRANT; HRQ = 0 in IDLE and RELEASE.
REQ-021 DREQ latency: DREQ asserted before edge 0 gives HRQ high after edge 2 (2 sync stages + 1 register). sw_req latency: HRQ rises on the next edge.
REQ-022 Winner selection happens on the REQ -> GRANT edge. grant_ch, grant_valid and the DACK bit of grant_ch all become active on that same edge.
REQ-023 Fixed priority: lowest index wins.
REQ-024 Rotating priority: after channel n completes via svc_done, priority order becomes n+1, n+2, n+3, n (mod 4). Wrap: after ch3 the order is 0,1,2,3.
REQ-025 Rotation pointer updates only on svc_done, never on abort. Its reset value makes ch0 highest.
REQ-026 At most one DACK bit is active at any time; every DACK bit is inactive outside GRANT.
REQ-027 grant_ch is held stable throughout GRANT. Mask changes, DREQ deassertion or ctrl_disable during GRANT do not end service.
REQ-028 HLDA sampled low while in GRANT: abort.
  - Next state IDLE.
  - DACK goes inactive and grant_valid drops on that edge.
  - No rotation.
REQ-029 ctrl_disable = 1 in REQ: next state RELEASE. ctrl_disable = 1 in IDLE: no HRQ.
REQ-030 svc_done outside GRANT is ignored.
REQ-031 A request pending in RELEASE is held off until IDLE is re-entered; minimum one IDLE cycle between services.

Reset
REQ-032 While RESET = 0 the block is asynchronously forced to:
  - FSM state IDLE.
  - HRQ = 0, grant_valid = 0, grant_ch = 0.
  - Synchronizer flops = inactive level.
  - Rotation pointer = ch0 highest.
REQ-033 During reset, DACK is at its inactive level per dack_sense (4'hF with dack_sense = 0).
REQ-034 Reset asserted mid-service ends the service immediately; no svc_done is required.

Structure
REQ-035 Shared package dma_pkg holds:
  - NUM_CH.
  - Channel-index typedef (2 bits).
  - FSM state enum {IDLE, REQ, GRANT, RELEASE}.
REQ-036 Sub-module dma_dreq_sync: SYNC_STAGES-deep per-bit synchronizer with the same CLK/RESET. Priority resolution stays inside dma_priority_arbiter.

Verification
REQ-037 Fixed priority: DREQ = 4'b0110, mask = 0, rot_pri = 0, HLDA raised 2 cycles after HRQ -> grant_ch = 1, DACK = 4'b1101 (dack_sense = 0).
REQ-038 Rotating priority: rot_pri = 1, DREQ = 4'b1111 held; complete each service with svc_done -> grant_ch sequence 0,1,2,3,0.
REQ-039 Mask and software request:
  - mask = 4'b0001, DREQ = 4'b0001 -> HRQ stays 0.
  - Then sw_req = 4'b1000 -> HRQ rises on the next edge, grant_ch = 3.
REQ-040 Abort: HLDA dropped in GRANT on ch2 with rot_pri = 1 -> DACK inactive next edge, state IDLE, next grant with all channels requesting = ch0 (pointer unchanged).
REQ-041 Reset mid-service: RESET = 0 during GRANT -> HRQ = 0 and grant_valid = 0 without waiting for a clock. After release with DREQ = 4'b0001, HRQ rises 3 edges later.
